// File: rtl/dataportarbiter.sv
// Dual-port data cache front end: in-order request queue that issues the oldest
// one or two requests per cycle and registers load responses with their tags.
module dataportarbiter #(
  parameter int dataSize   = 32,
  parameter int addrSize   = 32,
  parameter int queueDepth = 4,
  parameter int tagSize    = 4
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                reqValid1,
  input  logic                reqValid2,
  input  logic                reqWrite1,
  input  logic                reqWrite2,
  input  logic [addrSize-1:0] reqAddr1,
  input  logic [addrSize-1:0] reqAddr2,
  input  logic [dataSize-1:0] reqData1,
  input  logic [dataSize-1:0] reqData2,
  input  logic [tagSize-1:0]  reqTag1,
  input  logic [tagSize-1:0]  reqTag2,
  output logic                reqReady,
  output logic                writeEn1,
  output logic                writeEn2,
  output logic [addrSize-1:0] addr1,
  output logic [addrSize-1:0] addr2,
  output logic [dataSize-1:0] writeData1,
  output logic [dataSize-1:0] writeData2,
  input  logic [dataSize-1:0] readData1,
  input  logic [dataSize-1:0] readData2,
  output logic                rspValid1,
  output logic                rspValid2,
  output logic [dataSize-1:0] rspData1,
  output logic [dataSize-1:0] rspData2,
  output logic [tagSize-1:0]  rspTag1,
  output logic [tagSize-1:0]  rspTag2,
  output logic                empty
);
  localparam int ptrSize = $clog2(queueDepth);
  localparam logic [ptrSize:0] readyMax = (ptrSize+1)'(queueDepth - 2);
  localparam logic [ptrSize:0] oneCnt   = (ptrSize+1)'(1);
  localparam logic [ptrSize:0] twoCnt   = (ptrSize+1)'(2);

  logic                qWrite [queueDepth];
  logic [addrSize-1:0] qAddr  [queueDepth];
  logic [dataSize-1:0] qData  [queueDepth];
  logic [tagSize-1:0]  qTag   [queueDepth];

  logic [ptrSize-1:0] head, tail, headNext1, tailNext1;
  logic [ptrSize:0]   count, countNext, pushCnt, popCnt;
  logic               hazard, issue1, issue2, enqueue;

  assign headNext1 = head + ptrSize'(1);
  assign tailNext1 = tail + ptrSize'(1);

  assign reqReady = (count <= readyMax);
  assign enqueue  = reqValid1 & reqReady;

  // A same-word load/store pair would race inside the cache, so the younger one waits.
  assign hazard = (qAddr[head][addrSize-1:2] == qAddr[headNext1][addrSize-1:2]) &&
                  (qWrite[head] ^ qWrite[headNext1]);
  assign issue1 = (count != '0);
  assign issue2 = (count >= twoCnt) && !hazard;

  assign pushCnt   = enqueue ? (reqValid2 ? twoCnt : oneCnt) : '0;
  assign popCnt    = (ptrSize+1)'(issue1) + (ptrSize+1)'(issue2);
  assign countNext = count + pushCnt - popCnt;

  assign writeEn1   = issue1 & qWrite[head] & rstN;
  assign writeEn2   = issue2 & qWrite[headNext1] & rstN;
  assign addr1      = issue1 ? qAddr[head] : '0;
  assign addr2      = issue2 ? qAddr[headNext1] : '0;
  assign writeData1 = issue1 ? qData[head] : '0;
  assign writeData2 = issue2 ? qData[headNext1] : '0;

  always_ff @(posedge clk) begin
    if (enqueue) begin
      qWrite[tail] <= reqWrite1;
      qAddr[tail]  <= reqAddr1;
      qData[tail]  <= reqData1;
      qTag[tail]   <= reqTag1;
      if (reqValid2) begin
        qWrite[tailNext1] <= reqWrite2;
        qAddr[tailNext1]  <= reqAddr2;
        qData[tailNext1]  <= reqData2;
        qTag[tailNext1]   <= reqTag2;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      head  <= head + ptrSize'(popCnt);
      tail  <= tail + ptrSize'(pushCnt);
      count <= countNext;
      empty <= (countNext == '0);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rspValid1 <= 1'b0;
      rspValid2 <= 1'b0;
      rspData1  <= '0;
      rspData2  <= '0;
      rspTag1   <= '0;
      rspTag2   <= '0;
    end else begin
      rspValid1 <= issue1 & ~qWrite[head];
      rspValid2 <= issue2 & ~qWrite[headNext1];
      if (issue1 && !qWrite[head]) begin
        rspData1 <= readData1;
        rspTag1  <= qTag[head];
      end
      if (issue2 && !qWrite[headNext1]) begin
        rspData2 <= readData2;
        rspTag2  <= qTag[headNext1];
      end
    end
  end
endmodule

// File: tb/tb_dataportarbiter.sv
// Bench for dataportarbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a negedge-writing cache model.
module tb_dataportarbiter;
  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid1, reqValid2, reqWrite1, reqWrite2;
  logic [31:0] reqAddr1, reqAddr2, reqData1, reqData2;
  logic [3:0]  reqTag1, reqTag2;
  logic        reqReady, writeEn1, writeEn2;
  logic [31:0] addr1, addr2, writeData1, writeData2, readData1, readData2;
  logic        rspValid1, rspValid2;
  logic [31:0] rspData1, rspData2;
  logic [3:0]  rspTag1, rspTag2;
  logic        empty;

  dataportarbiter dut (
    .clk(clk), .rstN(rstN),
    .reqValid1(reqValid1), .reqValid2(reqValid2),
    .reqWrite1(reqWrite1), .reqWrite2(reqWrite2),
    .reqAddr1(reqAddr1), .reqAddr2(reqAddr2),
    .reqData1(reqData1), .reqData2(reqData2),
    .reqTag1(reqTag1), .reqTag2(reqTag2),
    .reqReady(reqReady),
    .writeEn1(writeEn1), .writeEn2(writeEn2),
    .addr1(addr1), .addr2(addr2),
    .writeData1(writeData1), .writeData2(writeData2),
    .readData1(readData1), .readData2(readData2),
    .rspValid1(rspValid1), .rspValid2(rspValid2),
    .rspData1(rspData1), .rspData2(rspData2),
    .rspTag1(rspTag1), .rspTag2(rspTag2),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Cache model: combinational read, write at the negedge, port 2 written last.
  bit [31:0] cacheMem [0:255];
  assign readData1 = cacheMem[addr1[9:2]];
  assign readData2 = cacheMem[addr2[9:2]];
  always @(negedge clk) begin
    if (rstN) begin
      if (writeEn1) cacheMem[addr1[9:2]] <= writeData1;
      if (writeEn2) cacheMem[addr2[9:2]] <= writeData2;
    end
  end

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  t;
  } req_t;

  req_t      refQ[$];
  bit [31:0] refMem [0:255];
  logic      eIss1, eIss2, eWe1, eWe2, eRdy, eEmpty;
  logic [31:0] eA1, eA2, eD1, eD2;
  logic      expV1, expV2;
  logic [31:0] expD1, expD2;
  logic [3:0]  expT1, expT2;
  int checks = 0;
  int errors = 0;

  function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] t);
    req_t r;
    r.w = w; r.a = a; r.d = d; r.t = t;
    return r;
  endfunction

  task automatic drive(input logic v1, input req_t r1, input logic v2, input req_t r2);
    reqValid1 = v1; reqWrite1 = r1.w; reqAddr1 = r1.a; reqData1 = r1.d; reqTag1 = r1.t;
    reqValid2 = v2; reqWrite2 = r2.w; reqAddr2 = r2.a; reqData2 = r2.d; reqTag2 = r2.t;
  endtask

  task automatic idle();
    drive(1'b0, mk(0, 0, 0, 0), 1'b0, mk(0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected port activity for the current cycle, from the queue contents.
  function automatic void modelExpect();
    eIss1 = refQ.size() >= 1;
    eIss2 = 1'b0;
    if (refQ.size() >= 2)
      eIss2 = !((refQ[0].a[31:2] == refQ[1].a[31:2]) && (refQ[0].w != refQ[1].w));
    eWe1 = eIss1 ? refQ[0].w : 1'b0;
    eA1  = eIss1 ? refQ[0].a : 32'd0;
    eD1  = eIss1 ? refQ[0].d : 32'd0;
    eWe2 = eIss2 ? refQ[1].w : 1'b0;
    eA2  = eIss2 ? refQ[1].a : 32'd0;
    eD2  = eIss2 ? refQ[1].d : 32'd0;
    eRdy   = refQ.size() <= 2;
    eEmpty = refQ.size() == 0;
  endfunction

  // Advance the model across one posedge: issue, respond, pop, then enqueue.
  function automatic void modelAdvance(input logic v1, input req_t r1, input logic v2, input req_t r2);
    bit rdy;
    rdy = refQ.size() <= 2;
    expV1 = 1'b0;
    expV2 = 1'b0;
    if (eWe1) refMem[eA1[9:2]] = eD1;
    if (eWe2) refMem[eA2[9:2]] = eD2;
    if (eIss1 && !eWe1) begin expV1 = 1'b1; expT1 = refQ[0].t; expD1 = refMem[eA1[9:2]]; end
    if (eIss2 && !eWe2) begin expV2 = 1'b1; expT2 = refQ[1].t; expD2 = refMem[eA2[9:2]]; end
    if (eIss1) void'(refQ.pop_front());
    if (eIss2) void'(refQ.pop_front());
    if (v1 && rdy) begin
      refQ.push_back(r1);
      if (v2) refQ.push_back(r2);
    end
  endfunction

  task automatic test_reset();
    rstN = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if ({writeEn1, writeEn2, rspValid1, rspValid2} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables got %b want 0000", {writeEn1, writeEn2, rspValid1, rspValid2});
    end
    checks++;
    if ({addr1, addr2, writeData1, writeData2} !== 128'd0) begin
      errors++; $display("FAIL reset_port_drive got %h %h %h %h want 0", addr1, addr2, writeData1, writeData2);
    end
    checks++;
    if ({rspData1, rspData2, rspTag1, rspTag2} !== 72'd0) begin
      errors++; $display("FAIL reset_rsp got %h %h %h %h want 0", rspData1, rspData2, rspTag1, rspTag2);
    end
    checks++;
    if (reqReady !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL reset_status got ready=%b empty=%b want 1 1", reqReady, empty);
    end
    #2 rstN = 1'b1;
    tick();
  endtask

  task automatic test_store_load_pair();
    drive(1'b1, mk(1, 32'h10, 32'hDEADBEEF, 0), 1'b1, mk(1, 32'h20, 32'h12345678, 0));
    tick();
    checks++;
    if ({writeEn1, writeEn2} !== 2'b11 || addr1 !== 32'h10 || addr2 !== 32'h20 ||
        writeData1 !== 32'hDEADBEEF || writeData2 !== 32'h12345678) begin
      errors++; $display("FAIL store_pair got we=%b%b a=%h/%h d=%h/%h", writeEn1, writeEn2, addr1, addr2, writeData1, writeData2);
    end
    drive(1'b1, mk(0, 32'h10, 0, 1), 1'b1, mk(0, 32'h20, 0, 2));
    tick();
    idle();
    checks++;
    if ({writeEn1, writeEn2} !== 2'b00 || addr1 !== 32'h10 || addr2 !== 32'h20 || rspValid1 !== 1'b0) begin
      errors++; $display("FAIL load_pair_issue got we=%b%b a=%h/%h rv=%b", writeEn1, writeEn2, addr1, addr2, rspValid1);
    end
    tick();
    checks++;
    if ({rspValid1, rspValid2} !== 2'b11 || rspData1 !== 32'hDEADBEEF || rspData2 !== 32'h12345678 ||
        rspTag1 !== 4'd1 || rspTag2 !== 4'd2) begin
      errors++; $display("FAIL load_pair_rsp got v=%b%b d=%h/%h t=%0d/%0d want 11 deadbeef/12345678 1/2", rspValid1, rspValid2, rspData1, rspData2, rspTag1, rspTag2);
    end
    tick();
    checks++;
    if ({rspValid1, rspValid2} !== 2'b00 || empty !== 1'b1) begin
      errors++; $display("FAIL rsp_pulse got v=%b%b empty=%b want 00 1", rspValid1, rspValid2, empty);
    end
  endtask

  task automatic test_store_then_load();
    drive(1'b1, mk(1, 32'h40, 32'hA5A5A5A5, 0), 1'b1, mk(0, 32'h40, 0, 3));
    tick();
    idle();
    checks++;
    if (writeEn1 !== 1'b1 || writeEn2 !== 1'b0 || addr2 !== 32'd0 || addr1 !== 32'h40) begin
      errors++; $display("FAIL st_ld_split got we=%b%b a1=%h a2=%h want 10 40 0", writeEn1, writeEn2, addr1, addr2);
    end
    tick();
    checks++;
    if (writeEn1 !== 1'b0 || addr1 !== 32'h40 || rspValid1 !== 1'b0) begin
      errors++; $display("FAIL st_ld_second got we=%b a1=%h rv=%b want 0 40 0", writeEn1, addr1, rspValid1);
    end
    tick();
    checks++;
    if (rspValid1 !== 1'b1 || rspValid2 !== 1'b0 || rspData1 !== 32'hA5A5A5A5 || rspTag1 !== 4'd3) begin
      errors++; $display("FAIL st_ld_rsp got v=%b%b d=%h t=%0d want 10 a5a5a5a5 3", rspValid1, rspValid2, rspData1, rspTag1);
    end
    tick();
  endtask

  task automatic test_load_then_store();
    drive(1'b1, mk(0, 32'h40, 0, 4), 1'b1, mk(1, 32'h40, 32'h1, 0));
    tick();
    idle();
    checks++;
    if (writeEn1 !== 1'b0 || writeEn2 !== 1'b0 || addr1 !== 32'h40 || addr2 !== 32'd0) begin
      errors++; $display("FAIL ld_st_split got we=%b%b a1=%h a2=%h want 00 40 0", writeEn1, writeEn2, addr1, addr2);
    end
    tick();
    checks++;
    if (rspValid1 !== 1'b1 || rspData1 !== 32'hA5A5A5A5 || rspTag1 !== 4'd4 ||
        writeEn1 !== 1'b1 || writeData1 !== 32'h1) begin
      errors++; $display("FAIL ld_st_rsp got v=%b d=%h t=%0d we=%b wd=%h want 1 a5a5a5a5 4 1 1", rspValid1, rspData1, rspTag1, writeEn1, writeData1);
    end
    drive(1'b1, mk(0, 32'h40, 0, 5), 1'b0, mk(0, 0, 0, 0));
    tick();
    idle();
    tick();
    checks++;
    if (rspValid1 !== 1'b1 || rspData1 !== 32'h1 || rspTag1 !== 4'd5) begin
      errors++; $display("FAIL ld_after_st got v=%b d=%h t=%0d want 1 1 5", rspValid1, rspData1, rspTag1);
    end
    tick();
  endtask

  task automatic test_store_store();
    drive(1'b1, mk(1, 32'h80, 32'h11, 0), 1'b1, mk(1, 32'h80, 32'h22, 0));
    tick();
    drive(1'b1, mk(0, 32'h80, 0, 6), 1'b0, mk(0, 0, 0, 0));
    checks++;
    if ({writeEn1, writeEn2} !== 2'b11 || addr1 !== 32'h80 || addr2 !== 32'h80 ||
        writeData1 !== 32'h11 || writeData2 !== 32'h22) begin
      errors++; $display("FAIL st_st_pair got we=%b%b a=%h/%h d=%h/%h", writeEn1, writeEn2, addr1, addr2, writeData1, writeData2);
    end
    tick();
    idle();
    tick();
    checks++;
    if (rspValid1 !== 1'b1 || rspData1 !== 32'h22 || rspTag1 !== 4'd6) begin
      errors++; $display("FAIL st_st_order got v=%b d=%h t=%0d want 1 22 6", rspValid1, rspData1, rspTag1);
    end
    tick();
  endtask

  task automatic test_random();
    req_t r1, r2;
    logic v1, v2;
    logic [7:0] wd1, wd2;
    refQ.delete();
    expV1 = 1'b0;
    expV2 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      modelExpect();
      checks++;
      if (writeEn1 !== eWe1 || addr1 !== eA1 || writeData1 !== eD1) begin
        errors++; $display("FAIL rand_port1 cyc %0d got we=%b a=%h d=%h want we=%b a=%h d=%h", c, writeEn1, addr1, writeData1, eWe1, eA1, eD1);
      end
      checks++;
      if (writeEn2 !== eWe2 || addr2 !== eA2 || writeData2 !== eD2) begin
        errors++; $display("FAIL rand_port2 cyc %0d got we=%b a=%h d=%h want we=%b a=%h d=%h", c, writeEn2, addr2, writeData2, eWe2, eA2, eD2);
      end
      checks++;
      if (reqReady !== eRdy || empty !== eEmpty) begin
        errors++; $display("FAIL rand_status cyc %0d got ready=%b empty=%b want %b %b", c, reqReady, empty, eRdy, eEmpty);
      end
      checks++;
      if (rspValid1 !== expV1 || rspValid2 !== expV2 ||
          (expV1 && (rspData1 !== expD1 || rspTag1 !== expT1)) ||
          (expV2 && (rspData2 !== expD2 || rspTag2 !== expT2))) begin
        errors++; $display("FAIL rand_rsp cyc %0d got v=%b%b d=%h/%h t=%0d/%0d want v=%b%b d=%h/%h t=%0d/%0d", c, rspValid1, rspValid2, rspData1, rspData2, rspTag1, rspTag2, expV1, expV2, expD1, expD2, expT1, expT2);
      end
      v1  = ($urandom_range(0, 3) != 0);
      v2  = v1 && ($urandom_range(0, 1) != 0);
      wd1 = 8'(64 + $urandom_range(0, 7));
      wd2 = 8'(64 + $urandom_range(0, 7));
      r1  = mk(1'($urandom_range(0, 1)), {22'd0, wd1, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      r2  = mk(1'($urandom_range(0, 1)), {22'd0, wd2, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      drive(v1, r1, v2, r2);
      modelAdvance(v1, r1, v2, r2);
      tick();
    end
    idle();
  endtask

  task automatic test_fill_and_reset();
    req_t r1, r2;
    bit sawNotReady = 0;
    logic [3:0] tagCnt = 4'd0;
    for (int c = 0; c < 14; c++) begin
      modelExpect();
      checks++;
      if (writeEn1 !== eWe1 || addr1 !== eA1 || writeEn2 !== eWe2 || addr2 !== eA2 ||
          writeData1 !== eD1 || writeData2 !== eD2) begin
        errors++; $display("FAIL fill_ports cyc %0d got we=%b%b a=%h/%h want we=%b%b a=%h/%h", c, writeEn1, writeEn2, addr1, addr2, eWe1, eWe2, eA1, eA2);
      end
      checks++;
      if (reqReady !== eRdy || empty !== eEmpty) begin
        errors++; $display("FAIL fill_ready cyc %0d got ready=%b empty=%b want %b %b", c, reqReady, empty, eRdy, eEmpty);
      end
      checks++;
      if (rspValid1 !== expV1 || rspValid2 !== expV2 || (expV1 && (rspData1 !== expD1 || rspTag1 !== expT1))) begin
        errors++; $display("FAIL fill_rsp cyc %0d got v=%b%b d=%h t=%0d want v=%b%b d=%h t=%0d", c, rspValid1, rspValid2, rspData1, rspTag1, expV1, expV2, expD1, expT1);
      end
      if (reqReady === 1'b0) sawNotReady = 1;
      r1 = mk(1'b1, 32'h118, $urandom, 4'd0);
      r2 = mk(1'b0, 32'h118, 32'd0, tagCnt);
      if (eRdy) tagCnt = tagCnt + 4'd1;
      drive(1'b1, r1, 1'b1, r2);
      modelAdvance(1'b1, r1, 1'b1, r2);
      tick();
    end
    checks++;
    if (!sawNotReady) begin
      errors++; $display("FAIL fill_backpressure got ready never low want low once count reached 3");
    end
    idle();
    #1 rstN = 1'b0;
    refQ.delete();
    expV1 = 1'b0;
    expV2 = 1'b0;
    #1;
    checks++;
    if ({writeEn1, writeEn2, rspValid1, rspValid2} !== 4'b0000 || empty !== 1'b1 || reqReady !== 1'b1) begin
      errors++; $display("FAIL async_reset got we=%b%b rv=%b%b empty=%b ready=%b want 0000 1 1", writeEn1, writeEn2, rspValid1, rspValid2, empty, reqReady);
    end
    @(posedge clk);
    #3 rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({rspValid1, rspValid2, writeEn1, writeEn2} !== 4'b0000 || empty !== 1'b1) begin
        errors++; $display("FAIL post_reset cyc %0d got rv=%b%b we=%b%b empty=%b want 0000 1", c, rspValid1, rspValid2, writeEn1, writeEn2, empty);
      end
    end
    drive(1'b1, mk(0, 32'h118, 0, 4'd9), 1'b0, mk(0, 0, 0, 0));
    tick();
    idle();
    tick();
    checks++;
    if (rspValid1 !== 1'b1 || rspData1 !== refMem[70] || rspTag1 !== 4'd9) begin
      errors++; $display("FAIL post_reset_load got v=%b d=%h t=%0d want 1 %h 9", rspValid1, rspData1, rspTag1, refMem[70]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load_pair();
    test_store_then_load();
    test_load_then_store();
    test_store_store();
    test_random();
    test_fill_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
